// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word-organised RAM, programmable wait states,
// byte/halfword/word writes and a two-cycle ERROR response for illegal transfers.
module ahb_mem_slave #(
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_WAIT       = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYout,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int LP_IDX_W = P_ADDR_WIDTH - 2;
  localparam int LP_WORDS = 2 ** LP_IDX_W;
  localparam logic [3:0] LP_WAIT_LOAD = (P_WAIT > 0) ? 4'(P_WAIT - 1) : 4'd0;
  localparam logic [1:0] LP_OKAY  = 2'b00;
  localparam logic [1:0] LP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OKAY_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                    state_q;
  logic [3:0]                cnt_q;
  logic [P_ADDR_WIDTH-1:0]   addr_q;
  logic                      write_q;
  logic [1:0]                size_q;
  logic                      hreadyout_q;
  logic [1:0]                hresp_q;
  logic [31:0]               hrdata_q;
  logic [31:0]               mem_q [LP_WORDS];

  logic                      accept;
  logic                      legal;
  logic                      can_accept;
  logic                      take;
  logic                      commit;
  logic [3:0]                wr_be;
  logic [31:0]               wr_mask;
  logic [31:0]               wr_word;
  logic [LP_IDX_W-1:0]       wr_idx;
  logic [LP_IDX_W-1:0]       rd_idx;
  logic [31:0]               rd_word;

  // Burst type, protection, BUSY/IDLE distinction and aliased address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0], HADDR[31:P_ADDR_WIDTH]};

  assign accept     = HSEL && HREADY && HTRANS[1];
  assign legal      = (HSIZE == 3'd0)
                   || ((HSIZE == 3'd1) && !HADDR[0])
                   || ((HSIZE == 3'd2) && (HADDR[1:0] == 2'b00));
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign take       = can_accept && accept;
  assign commit     = (state_q == ST_DATA) && write_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_be = 4'b0000;
    unique case (size_q)
      2'd0:    wr_be[addr_q[1:0]] = 1'b1;
      2'd1:    wr_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  assign wr_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
  assign wr_idx  = addr_q[P_ADDR_WIDTH-1:2];
  assign wr_word = (mem_q[wr_idx] & ~wr_mask) | (HWDATA & wr_mask);

  // A read loaded on the same edge a write commits sees the merged word, not the stale RAM entry.
  assign rd_idx  = take ? HADDR[P_ADDR_WIDTH-1:2] : addr_q[P_ADDR_WIDTH-1:2];
  assign rd_word = (commit && (wr_idx == rd_idx)) ? wr_word : mem_q[rd_idx];

  // NOTE: RAM has no reset; contents survive HRESETn and only the control path is cleared.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= LP_OKAY;
      hrdata_q    <= '0;
    end else begin
      hrdata_q <= '0;
      unique case (state_q)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (take) begin
            addr_q  <= HADDR[P_ADDR_WIDTH-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
            if (!legal) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= LP_ERROR;
            end else if (P_WAIT == 0) begin
              state_q     <= ST_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= LP_OKAY;
              hrdata_q    <= HWRITE ? 32'd0 : rd_word;
            end else begin
              state_q     <= ST_OKAY_WAIT;
              cnt_q       <= LP_WAIT_LOAD;
              hreadyout_q <= 1'b0;
              hresp_q     <= LP_OKAY;
            end
          end else if (state_q != ST_IDLE) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= LP_OKAY;
          end
        end
        ST_OKAY_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_DATA;
            hreadyout_q <= 1'b1;
            hrdata_q    <= write_q ? 32'd0 : rd_word;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= LP_ERROR;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= LP_OKAY;
        end
      endcase
    end
  end

  assign HREADYout = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Two memory slaves (zero and three wait states) behind a small bus mux, driven by a pipelined
// master; a scoreboard compares every completed data phase with a byte-level memory model.
module tb_ahb_mem_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL0, HSEL1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rd0, rd1;
  logic        dsel = 1'b0;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  int          cyc = 0;

  always #5 HCLK = ~HCLK;

  ahb_mem_slave #(.P_ADDR_WIDTH(12), .P_WAIT(0)) u_s0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYout(rdy0), .HRESP(resp0), .HRDATA(rd0));

  ahb_mem_slave #(.P_ADDR_WIDTH(12), .P_WAIT(3)) u_s1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYout(rdy1), .HRESP(resp1), .HRDATA(rd1));

  // Interconnect: the slave owning the current data phase drives the shared response.
  assign HREADY = dsel ? rdy1 : rdy0;
  assign HRESP  = dsel ? resp1 : resp0;
  assign HRDATA = dsel ? rd1 : rd0;

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (HREADY === 1'b1) dsel <= HSEL1;
  end

  typedef struct {
    bit          sel;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_m [2][4096];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  function automatic logic [31:0] model_read(input bit s, input logic [31:0] a);
    int base;
    base = int'(a % 4096) / 4 * 4;
    return {mem_m[s][base+3], mem_m[s][base+2], mem_m[s][base+1], mem_m[s][base]};
  endfunction

  task automatic model_write(input bit s, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int off;
    off = int'(a % 4096);
    for (int k = 0; k < (1 << sz); k++) begin
      mem_m[s][off+k] = wd[8*((off+k)%4) +: 8];
    end
  endtask

  task automatic bus_idle();
    HSEL0  = 1'b0;
    HSEL1  = 1'b0;
    HTRANS = 2'b00;
  endtask

  // One pipelined transfer: hold the address phase until accepted, then drive its write data.
  task automatic issue(input bit s, input logic [31:0] a, input bit w, input logic [2:0] sz,
                       input logic [31:0] wd, input bit commit, output int acc_cyc);
    exp_t e;
    bit   rdy;
    bit   legal;
    int   n;
    HSEL0  = !s;
    HSEL1  = s;
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = w;
    HSIZE  = sz;
    HBURST = 3'($urandom_range(0, 7));
    HPROT  = 4'($urandom_range(0, 15));
    n = 0;
    do begin
      @(negedge HCLK);
      rdy = (HREADY === 1'b1);
      @(posedge HCLK);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      check("accept_timeout", 32'(rdy), 32'd1);
      summary();
    end
    #1;
    acc_cyc = cyc;
    HWDATA  = wd;
    legal   = (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0);
    e.sel   = s;
    e.err   = !legal;
    e.waits = !legal ? 1 : (s ? 3 : 0);
    e.rdata = (!legal || w) ? 32'd0 : model_read(s, a);
    if (legal && w && commit) model_write(s, a, sz, wd);
    exp_q.push_back(e);
    bus_idle();
  endtask

  task automatic bus_cycle(input bit s, input logic [1:0] tr);
    HSEL0  = !s;
    HSEL1  = s;
    HTRANS = tr;
    HADDR  = $urandom;
    HWRITE = 1'b1;
    @(posedge HCLK);
    #1;
    bus_idle();
  endtask

  // Monitor: counts wait cycles of each data phase and checks it when HREADY completes it.
  bit dp_active = 1'b0;
  int wcnt      = 0;

  always @(negedge HCLK) begin
    exp_t e;
    if (HRESETn !== 1'b1) begin
      exp_q.delete();
      dp_active = 1'b0;
      wcnt      = 0;
    end else begin
      if (dp_active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_data_phase", 32'd1, 32'd0);
          dp_active = 1'b0;
        end else if (HREADY !== 1'b1) begin
          e = exp_q[0];
          wcnt++;
          check("wait_hresp", 32'(HRESP), e.err ? 32'd1 : 32'd0);
          check("wait_hrdata", HRDATA, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(e.err ? "err2_hresp" : "okay_hresp", 32'(HRESP), e.err ? 32'd1 : 32'd0);
          check(e.sel ? "s1_hrdata" : "s0_hrdata", HRDATA, e.rdata);
          check(e.sel ? "s1_wait_cycles" : "s0_wait_cycles", 32'(wcnt), 32'(e.waits));
          wcnt = 0;
        end
      end
      if (HREADY === 1'b1) dp_active = HTRANS[1] && (HSEL0 || HSEL1);
    end
  end

  initial begin
    int c1, c2, dummy, n;
    logic [31:0] a, last_a;
    logic [2:0]  sz;
    int          r;

    HRESETn = 1'b0;
    bus_idle();
    HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = '0; HPROT = '0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_s0_hreadyout", 32'(rdy0), 32'd1);
    check("rst_s0_hresp", 32'(resp0), 32'd0);
    check("rst_s0_hrdata", rd0, 32'd0);
    check("rst_s1_hreadyout", 32'(rdy1), 32'd1);
    check("rst_s1_hresp", 32'(resp1), 32'd0);
    check("rst_s1_hrdata", rd1, 32'd0);
    HRESETn = 1'b1;

    // Give the low 256 bytes of both RAMs known contents.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++)
        issue(s[0], 32'(i * 4), 1'b1, 3'd2, $urandom, 1'b1, dummy);

    // Back-to-back write then read of the same word, with no idle cycle between them.
    issue(1'b0, 32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1, c1);
    issue(1'b0, 32'h010, 1'b0, 3'd2, $urandom, 1'b1, c2);
    check("b2b_accept_gap", 32'(c2 - c1), 32'd1);
    issue(1'b1, 32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1, dummy);
    issue(1'b1, 32'h010, 1'b0, 3'd2, $urandom, 1'b1, dummy);

    // Sub-word lanes, then illegal transfers that must not disturb the word.
    for (int s = 0; s < 2; s++) begin
      issue(s[0], 32'h011, 1'b1, 3'd0, 32'h0000AA00, 1'b1, dummy);
      issue(s[0], 32'h012, 1'b1, 3'd1, 32'h12340000, 1'b1, dummy);
      issue(s[0], 32'h010, 1'b0, 3'd2, $urandom, 1'b1, dummy);
      issue(s[0], 32'h013, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, dummy);
      issue(s[0], 32'h010, 1'b0, 3'd2, $urandom, 1'b1, dummy);
      issue(s[0], 32'h020, 1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, dummy);
      issue(s[0], 32'h010, 1'b0, 3'd2, $urandom, 1'b1, dummy);
      issue(s[0], 32'h0000_1040, 1'b1, 3'd2, 32'h55AA55AA, 1'b1, dummy);
      bus_cycle(s[0], 2'b00);
      bus_cycle(s[0], 2'b01);
      issue(s[0], 32'h040, 1'b0, 3'd2, $urandom, 1'b1, dummy);
    end

    // Reset during the second wait cycle of a write abandons that write.
    issue(1'b1, 32'h040, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, dummy);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    check("midrst_hreadyout", 32'(rdy1), 32'd1);
    check("midrst_hresp", 32'(resp1), 32'd0);
    check("midrst_hrdata", rd1, 32'd0);
    HRESETn = 1'b1;
    issue(1'b1, 32'h040, 1'b0, 3'd2, $urandom, 1'b1, dummy);

    // Randomized mix across both slaves, sizes, alignments and aliased addresses.
    last_a = 32'h0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) bus_cycle(1'($urandom), 2'($urandom_range(0, 1)));
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 3'd3 : 3'(r % 3);
      a  = ($urandom_range(0, 9) < 3) ? last_a
           : (($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)));
      a  = (a & ~32'h3) | 32'($urandom_range(0, 3));
      last_a = a;
      issue(1'($urandom), a, 1'($urandom), sz, $urandom, 1'b1, dummy);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge HCLK);
      n++;
    end
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    summary();
  end

endmodule
